// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : mips_pkg                                                |
// | Purpose    : Shared constants and types for the MIPS front end:      |
// |              word width, reset/exception vector defaults, PC         |
// |              sequencer state encodings, redirect kinds and an        |
// |              address word-align helper.                              |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;

  // Sequencer state encodings (visible on the debug port).
  localparam logic [1:0] SEQ_BOOT     = 2'd0;
  localparam logic [1:0] SEQ_RUN      = 2'd1;
  localparam logic [1:0] SEQ_STALL    = 2'd2;
  localparam logic [1:0] SEQ_REDIRECT = 2'd3;

  // Which redirect source won arbitration this cycle.
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_EXC    = 2'd1,
    REDIR_BRANCH = 2'd2,
    REDIR_JUMP   = 2'd3
  } redir_e;

  // Instruction fetch is word-granular: drop the byte-offset bits.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : next_pc_mux                                             |
// | Purpose    : Combinational priority select of the next PC:           |
// |              exception > branch > jump > stall(hold) > sequential.   |
// | Ports      : i_pc, i_pc_add        current PC and PC + step          |
// |              i_exc_req             exception request                 |
// |              i_branch_taken/target branch redirect from EX           |
// |              i_jump_taken/target   jump redirect from ID             |
// |              i_stall               hazard hold request               |
// |              o_next_pc             selected next PC (word aligned)   |
// |              o_redir               winning redirect kind             |
// |              o_align_fault         accepted target was misaligned    |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module next_pc_mux
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_pc_add,
  input  logic              i_exc_req,
  input  logic              i_branch_taken,
  input  logic [WORD_W-1:0] i_branch_target,
  input  logic              i_jump_taken,
  input  logic [WORD_W-1:0] i_jump_target,
  input  logic              i_stall,
  output logic [WORD_W-1:0] o_next_pc,
  output redir_e            o_redir,
  output logic              o_align_fault
);

  always_comb begin
    o_next_pc     = i_pc_add;
    o_redir       = REDIR_NONE;
    o_align_fault = 1'b0;
    if (i_exc_req) begin
      o_next_pc = word_align(EXC_VECTOR);
      o_redir   = REDIR_EXC;
    end else if (i_branch_taken) begin
      // A simultaneous jump is on the wrong path and is simply dropped.
      o_next_pc     = word_align(i_branch_target);
      o_redir       = REDIR_BRANCH;
      o_align_fault = |i_branch_target[1:0];
    end else if (i_jump_taken) begin
      o_next_pc     = word_align(i_jump_target);
      o_redir       = REDIR_JUMP;
      o_align_fault = |i_jump_target[1:0];
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : pc_sequencer                                            |
// | Purpose    : Program counter and next-PC sequencing for the 5-stage  |
// |              MIPS pipeline. Holds the PC register, the PC+step adder |
// |              and the BOOT/RUN/STALL/REDIRECT FSM; drives IF/ID load  |
// |              enable and the IF/ID, ID/EX flushes.                    |
// | Ports      : Clk, Reset_n (async, active-low)                        |
// |              Stall, JumpTaken/JumpTarget, BranchTaken/BranchTarget,  |
// |              ExcReq                          control inputs          |
// |              PCResult, PCAddResult           PC and PC + PC_STEP     |
// |              IFIDWrite, FlushIFID, FlushIDEX pipeline controls       |
// |              AlignFault                      misaligned target pulse |
// |              SeqState                        FSM state (debug)       |
// | Options    : BRANCH_DELAY_SLOT_EN - delay-slot flush behaviour:      |
// |              branch flushes IF/ID only, jump flushes nothing.        |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [WORD_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int                PC_STEP      = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              JumpTaken,
  input  logic [WORD_W-1:0] JumpTarget,
  input  logic              BranchTaken,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic              ExcReq,
  output logic [WORD_W-1:0] PCResult,
  output logic [WORD_W-1:0] PCAddResult,
  output logic              IFIDWrite,
  output logic              FlushIFID,
  output logic              FlushIDEX,
  output logic              AlignFault,
  output logic [1:0]        SeqState
);

  localparam logic [WORD_W-1:0] c_pc_step = PC_STEP[WORD_W-1:0];

`ifdef BRANCH_DELAY_SLOT_EN
  // The delay-slot instruction (in IF/ID behind a branch, or fetched
  // behind a jump) must commit.
  localparam logic c_branch_flush_idex = 1'b0;
  localparam logic c_jump_flush_ifid   = 1'b0;
`else
  localparam logic c_branch_flush_idex = 1'b1;
  localparam logic c_jump_flush_ifid   = 1'b1;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_add;
  logic [WORD_W-1:0] w_mux_pc;
  logic [WORD_W-1:0] w_pc_nxt;
  redir_e            w_redir;
  logic              w_mux_align_fault;

  // Modulo-2^32 increment: wraps from 0xFFFF_FFFC to 0 silently.
  assign w_pc_add = r_pc + c_pc_step;

  next_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_mux (
    .i_pc            (r_pc),
    .i_pc_add        (w_pc_add),
    .i_exc_req       (ExcReq),
    .i_branch_taken  (BranchTaken),
    .i_branch_target (BranchTarget),
    .i_jump_taken    (JumpTaken),
    .i_jump_target   (JumpTarget),
    .i_stall         (Stall),
    .o_next_pc       (w_mux_pc),
    .o_redir         (w_redir),
    .o_align_fault   (w_mux_align_fault)
  );

  // BOOT ignores every input and just holds the PC for one cycle.
  assign w_pc_nxt = (r_state == SEQ_BOOT) ? r_pc : w_mux_pc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_pc <= RESET_VECTOR;
    else          r_pc <= w_pc_nxt;
  end

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= SEQ_BOOT;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state. RUN, STALL and REDIRECT arbitrate identically.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEQ_BOOT: w_state_nxt = SEQ_RUN;
      default: begin
        if (w_redir != REDIR_NONE) w_state_nxt = SEQ_REDIRECT;
        else if (Stall)            w_state_nxt = SEQ_STALL;
        else                       w_state_nxt = SEQ_RUN;
      end
    endcase
  end

  // FSM: outputs. IFIDWrite stays high on a redirect; a flush on the same
  // edge clears the register regardless.
  always_comb begin
    IFIDWrite  = 1'b0;
    FlushIFID  = 1'b0;
    FlushIDEX  = 1'b0;
    AlignFault = 1'b0;
    if (r_state != SEQ_BOOT) begin
      IFIDWrite  = 1'b1;
      AlignFault = w_mux_align_fault;
      case (w_redir)
        REDIR_EXC: begin
          FlushIFID = 1'b1;
          FlushIDEX = 1'b1;
        end
        REDIR_BRANCH: begin
          FlushIFID = 1'b1;
          FlushIDEX = c_branch_flush_idex;
        end
        REDIR_JUMP: begin
          FlushIFID = c_jump_flush_ifid;
        end
        default: begin
          IFIDWrite = ~Stall;
        end
      endcase
    end
  end

  assign PCResult    = r_pc;
  assign PCAddResult = w_pc_add;
  assign SeqState    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_pc_sequencer                                         |
// | Purpose    : Self-checking bench for pc_sequencer: directed cases    |
// |              with literal expectations, then randomized control      |
// |              traffic checked every cycle against a behavioural model.|
// | Options    : BRANCH_DELAY_SLOT_EN selects delay-slot expectations.   |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        JumpTaken = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        ExcReq = 1'b0;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        IFIDWrite;
  logic        FlushIFID;
  logic        FlushIDEX;
  logic        AlignFault;
  logic [1:0]  SeqState;

  int nvec = 0;
  int nerr = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Stall        (Stall),
    .JumpTaken    (JumpTaken),
    .JumpTarget   (JumpTarget),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .ExcReq       (ExcReq),
    .PCResult     (PCResult),
    .PCAddResult  (PCAddResult),
    .IFIDWrite    (IFIDWrite),
    .FlushIFID    (FlushIFID),
    .FlushIDEX    (FlushIDEX),
    .AlignFault   (AlignFault),
    .SeqState     (SeqState)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  // m_boot: the single post-reset cycle in which nothing is fetched.
  // m_state is only the expected debug code; behaviour is driven by rules.
  logic [31:0] m_pc = 32'h0;
  logic [1:0]  m_state = 2'd0;
  logic [31:0] e_npc;
  logic [1:0]  e_nst;
  logic        x_ifid, x_fi, x_fe, x_af;
  logic [31:0] x_pc;
  logic [1:0]  x_st;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Literal (hand-computed) check.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    cmp(name, act, exp);
  endtask

  // Compare process: predicts this cycle's outputs and next PC from the rules.
  always @(negedge Clk) begin
    x_pc = m_pc; x_st = m_state;
    x_ifid = 1'b0; x_fi = 1'b0; x_fe = 1'b0; x_af = 1'b0;
    e_npc = m_pc; e_nst = m_state;
    if (!Reset_n) begin
      x_pc = 32'h0; x_st = 2'd0; e_npc = 32'h0; e_nst = 2'd0;
    end else if (m_state == 2'd0) begin
      e_nst = 2'd1;
    end else begin
      x_ifid = 1'b1;
      e_nst  = 2'd3;
      if (ExcReq) begin
        e_npc = 32'h8000_0180; x_fi = 1'b1; x_fe = 1'b1;
      end else if (BranchTaken) begin
        e_npc = BranchTarget - (BranchTarget % 4);
        x_af  = (BranchTarget % 4) != 0;
        x_fi  = 1'b1; x_fe = !DS;
      end else if (JumpTaken) begin
        e_npc = JumpTarget - (JumpTarget % 4);
        x_af  = (JumpTarget % 4) != 0;
        x_fi  = !DS;
      end else if (Stall) begin
        x_ifid = 1'b0; e_nst = 2'd2;
      end else begin
        e_npc = m_pc + 32'd4; e_nst = 2'd1;
      end
    end
    nvec++;
    cmp("PCResult",    PCResult,            x_pc);
    cmp("PCAddResult", PCAddResult,         x_pc + 32'd4);
    cmp("SeqState",    {30'd0, SeqState},   {30'd0, x_st});
    cmp("IFIDWrite",   {31'd0, IFIDWrite},  {31'd0, x_ifid});
    cmp("FlushIFID",   {31'd0, FlushIFID},  {31'd0, x_fi});
    cmp("FlushIDEX",   {31'd0, FlushIDEX},  {31'd0, x_fe});
    cmp("AlignFault",  {31'd0, AlignFault}, {31'd0, x_af});
  end

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_pc = 32'h0; m_state = 2'd0;
    end else begin
      m_pc = e_npc; m_state = e_nst;
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+3 with outputs settled.
  task automatic drive(input bit st, input bit jt, input logic [31:0] jtg,
                       input bit bt, input logic [31:0] btg, input bit ex);
    Stall = st; JumpTaken = jt; JumpTarget = jtg;
    BranchTaken = bt; BranchTarget = btg; ExcReq = ex;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic next();
    @(posedge Clk); #1;
  endtask

  initial begin
    @(posedge Clk); @(posedge Clk); #1;
    idle();
    chk("reset PCResult", PCResult, 32'h0);
    chk("reset SeqState", {30'd0, SeqState}, 32'd0);
    chk("reset IFIDWrite", {31'd0, IFIDWrite}, 32'd0);
    chk("reset FlushIFID", {31'd0, FlushIFID}, 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("boot IFIDWrite", {31'd0, IFIDWrite}, 32'd0);
    chk("boot SeqState", {30'd0, SeqState}, 32'd0);
    next(); idle();
    chk("run0 PCResult", PCResult, 32'h0);
    chk("run0 IFIDWrite", {31'd0, IFIDWrite}, 32'd1);
    next(); idle(); chk("seq PC 4", PCResult, 32'h4);
    next(); idle(); chk("seq PC 8", PCResult, 32'h8);
    next(); idle(); chk("seq PC 12", PCResult, 32'hC);
    next();
    // Stall for three cycles at 0x10.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0);
      chk("stall PCResult", PCResult, 32'h10);
      chk("stall IFIDWrite", {31'd0, IFIDWrite}, 32'd0);
      next();
    end
    idle();
    chk("stall SeqState", {30'd0, SeqState}, 32'd2);
    next(); idle(); chk("post-stall PC", PCResult, 32'h14);
    next();
    // Branch beats jump and stall.
    drive(1, 1, 32'h40, 1, 32'h100, 0);
    chk("branch FlushIFID", {31'd0, FlushIFID}, 32'd1);
    chk("branch FlushIDEX", {31'd0, FlushIDEX}, {31'd0, !DS});
    next(); idle();
    chk("branch PCResult", PCResult, 32'h100);
    chk("branch SeqState", {30'd0, SeqState}, 32'd3);
    next(); idle();
    chk("after branch PC", PCResult, 32'h104);
    chk("after branch SeqState", {30'd0, SeqState}, 32'd1);
    next();
    // Misaligned jump.
    drive(0, 1, 32'h203, 0, 32'h0, 0);
    chk("jump AlignFault", {31'd0, AlignFault}, 32'd1);
    chk("jump FlushIFID", {31'd0, FlushIFID}, {31'd0, !DS});
    chk("jump FlushIDEX", {31'd0, FlushIDEX}, 32'd0);
    next(); idle();
    chk("jump PCResult", PCResult, 32'h200);
    chk("jump AlignFault pulse", {31'd0, AlignFault}, 32'd0);
    next();
    // Wrap-around.
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    next(); idle();
    chk("wrap PCAddResult", PCAddResult, 32'h0);
    next(); idle();
    chk("wrap PCResult", PCResult, 32'h0);
    chk("wrap AlignFault", {31'd0, AlignFault}, 32'd0);
    next();
    // Exception beats branch.
    drive(0, 0, 32'h0, 1, 32'h300, 1);
    chk("exc FlushIDEX", {31'd0, FlushIDEX}, 32'd1);
    next(); idle();
    chk("exc PCResult", PCResult, 32'h8000_0180);
    next();
    // Reset while in REDIRECT.
    drive(0, 1, 32'h500, 0, 32'h0, 0);
    next(); idle();
    chk("pre-reset SeqState", {30'd0, SeqState}, 32'd3);
    Reset_n = 1'b0;
    #1;
    chk("async reset PCResult", PCResult, 32'h0);
    chk("async reset SeqState", {30'd0, SeqState}, 32'd0);
    next(); idle();
    Reset_n = 1'b1;
    next();
    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) Reset_n = 1'b0;
      else                             Reset_n = 1'b1;
      next();
    end
    idle();
    Reset_n = 1'b1;
    next(); next();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
